// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a 16x oversampled bit clock and a small input FIFO.
// Bytes are pushed with valid/ready and sent LSB first; queued frames follow each other with no idle gap.
module uart_tx_fifo #(
    parameter logic [7:0] CLK_DIV = 8'h1A,
    parameter int         ADDR_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic            txout,
    output logic            tx_busy,
    output logic [ADDR_W:0] fifo_count
);

    localparam int             DEPTH    = 2**ADDR_W;
    localparam logic [8:0]     TICK_MAX = 9'(2 * (int'(CLK_DIV) + 1) - 1);
    localparam logic [ADDR_W:0] FULL    = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [8:0]        div_cnt;
    logic              tick;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              push;
    logic              pop;
    logic [7:0]        head;
    state_t            state;
    logic [7:0]        shift;
    logic [3:0]        bit_tick;
    logic [2:0]        bit_idx;
    logic              txout_reg;
    logic              busy_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == TICK_MAX) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 9'd1;
        end
    end

    assign tick = (div_cnt == TICK_MAX);

    assign tx_ready   = (count != FULL);
    assign push       = tx_valid && tx_ready;
    // A byte leaves the FIFO only when a new frame starts: from IDLE, or at the end of a stop bit.
    assign pop        = tick && (count != '0) &&
                        ((state == IDLE) || ((state == STOP) && (bit_tick == 4'd15)));
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign txout      = txout_reg;
    assign tx_busy    = busy_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            bit_tick  <= '0;
            bit_idx   <= '0;
            txout_reg <= 1'b1;
            busy_reg  <= 1'b0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift     <= head;
                        state     <= START;
                        txout_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        bit_tick  <= '0;
                    end
                end
                START: begin
                    bit_tick <= bit_tick + 4'd1;
                    if (bit_tick == 4'd15) begin
                        state     <= DATA;
                        bit_idx   <= '0;
                        txout_reg <= shift[0];
                    end
                end
                DATA: begin
                    bit_tick <= bit_tick + 4'd1;
                    if (bit_tick == 4'd15) begin
                        if (bit_idx == 3'd7) begin
                            state     <= STOP;
                            txout_reg <= 1'b1;
                        end else begin
                            shift     <= shift >> 1;
                            bit_idx   <= bit_idx + 3'd1;
                            txout_reg <= shift[1];
                        end
                    end
                end
                STOP: begin
                    bit_tick <= bit_tick + 4'd1;
                    if (bit_tick == 4'd15) begin
                        if (pop) begin
                            shift     <= head;
                            state     <= START;
                            txout_reg <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            busy_reg <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shape and bit timing, back-to-back frames, full FIFO,
// reset mid-frame, simultaneous push/pop and a byte-recovery check. A small divider keeps runs short.
module tb_uart_tx_fifo;

    localparam logic [7:0] CLK_DIV = 8'd4;
    localparam int         ADDR_W  = 2;
    localparam int         TICK_P  = 2 * (int'(CLK_DIV) + 1);
    localparam int         BIT     = 16 * TICK_P;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            txout;
    logic            tx_busy;
    logic [ADDR_W:0] fifo_count;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .txout(txout), .tx_busy(tx_busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Returns the number of negedges waited until txout is seen low (bounded by limit).
    task automatic wait_start(input int limit, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        while (!found && n < limit) begin
            @(negedge clk);
            n++;
            if (txout === 1'b0) found = 1'b1;
        end
        chk("start_found", {31'd0, found}, 32'd1);
    endtask

    // Called on the first cycle of the start bit; returns on the last cycle of the stop bit.
    task automatic rx_body(input logic [7:0] exp, input string tag);
        logic [9:0] frame;
        logic       lvl;
        frame = {1'b1, exp, 1'b0};
        chk({tag, "_busy"}, {31'd0, tx_busy}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            lvl = txout;
            chk($sformatf("%s_bit%0d", tag, k), {31'd0, lvl}, {31'd0, frame[k]});
            repeat (BIT - 1) @(negedge clk);
            chk($sformatf("%s_hold%0d", tag, k), {31'd0, txout}, {31'd0, lvl});
            if (k < 9) @(negedge clk);
        end
    endtask

    task automatic idle_watch(input int cycles, input string tag);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (txout !== 1'b1) lows++;
        end
        chk(tag, lows, 0);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txout", {31'd0, txout}, 32'd1);
        chk("rst_busy",  {31'd0, tx_busy}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        reset = 1'b0;

        // Single byte 0x39: line sequence 0,1,0,0,1,1,1,0,0,1
        push(8'h39);
        chk("single_count", {29'd0, fifo_count}, 32'd1);
        wait_start(4 * TICK_P, n);
        chk("single_latency_ok", {31'd0, (n <= TICK_P)}, 32'd1);
        chk("single_popped", {29'd0, fifo_count}, 32'd0);
        rx_body(8'h39, "single");
        @(negedge clk);
        chk("single_idle_txout", {31'd0, txout}, 32'd1);
        chk("single_idle_busy",  {31'd0, tx_busy}, 32'd0);
        idle_watch(2 * BIT, "single_stays_high");

        // Back-to-back frames with no idle gap
        push(8'h55);
        push(8'hA3);
        wait_start(4 * TICK_P, n);
        rx_body(8'h55, "b2b1");
        wait_start(4 * TICK_P, n);
        chk("b2b_gap", n, 1);
        rx_body(8'hA3, "b2b2");
        @(negedge clk);
        chk("b2b_end_busy", {31'd0, tx_busy}, 32'd0);

        // Full FIFO while frame 1 is on the line; the sixth byte must be refused
        push(8'h11);
        wait_start(4 * TICK_P, n);
        fork
            rx_body(8'h11, "full1");
            begin
                push(8'h22);
                push(8'h33);
                push(8'h44);
                push(8'h55);
                chk("full_count", {29'd0, fifo_count}, 32'd4);
                chk("full_ready", {31'd0, tx_ready}, 32'd0);
                tx_data  = 8'h66;
                tx_valid = 1'b1;
                repeat (4) @(negedge clk);
                tx_valid = 1'b0;
                chk("full_no_overflow", {29'd0, fifo_count}, 32'd4);
            end
        join
        wait_start(4 * TICK_P, n);
        chk("full_gap2", n, 1);
        rx_body(8'h22, "full2");
        wait_start(4 * TICK_P, n);
        rx_body(8'h33, "full3");
        wait_start(4 * TICK_P, n);
        rx_body(8'h44, "full4");
        wait_start(4 * TICK_P, n);
        rx_body(8'h55, "full5");
        idle_watch(2 * BIT, "full_no_sixth");

        // Reset during data bit 3 of 0xF0 with two bytes queued
        push(8'hF0);
        wait_start(4 * TICK_P, n);
        push(8'h01);
        push(8'h02);
        repeat (4 * BIT + BIT / 2 - 2) @(negedge clk);
        chk("abort_pre_txout", {31'd0, txout}, 32'd0);
        chk("abort_pre_count", {29'd0, fifo_count}, 32'd2);
        reset = 1'b1;
        #1;
        chk("abort_txout", {31'd0, txout}, 32'd1);
        chk("abort_count", {29'd0, fifo_count}, 32'd0);
        chk("abort_busy",  {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_watch(3 * BIT, "abort_stays_high");
        chk("abort_count_after", {29'd0, fifo_count}, 32'd0);

        // Push on the exact cycle of a frame-start pop, with two bytes queued
        push(8'h10);
        wait_start(4 * TICK_P, n);
        fork
            rx_body(8'h10, "pp1");
            begin
                push(8'h20);
                push(8'h30);
            end
        join
        chk("pp_count_before", {29'd0, fifo_count}, 32'd2);
        tx_data  = 8'h40;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("pp_count_after", {29'd0, fifo_count}, 32'd2);
        chk("pp_no_gap", {31'd0, txout}, 32'd0);
        rx_body(8'h20, "pp2");
        wait_start(4 * TICK_P, n);
        rx_body(8'h30, "pp3");
        wait_start(4 * TICK_P, n);
        rx_body(8'h40, "pp4");

        // Byte recovery of edge-case patterns
        push(8'h00);
        push(8'hFF);
        push(8'h39);
        wait_start(4 * TICK_P, n);
        rx_body(8'h00, "lb00");
        wait_start(4 * TICK_P, n);
        rx_body(8'hFF, "lbFF");
        wait_start(4 * TICK_P, n);
        rx_body(8'h39, "lb39");
        @(negedge clk);
        chk("lb_end_busy", {31'd0, tx_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit half of the UART: 8N1 serializer with a 16x oversampled bit clock and a small input FIFO.
- A host pushes bytes through a valid/ready handshake; the block drives the serial line `txout`, LSB first.
- Bit timing uses the same 16x divider scheme as the receive path: 57600 baud from 50 MHz at the default setting. This lets the transmitter loop back into the receiver.

Parameters:
- CLK_DIV, 8'h1A, 16x tick period = 2*(CLK_DIV+1) clk cycles (default 54 cycles; bit time = 864 cycles).
- ADDR_W, 2, FIFO address width; depth = 2**ADDR_W (default 4 entries).

Ports:
- clk  input  1  system clock (50 MHz nominal)
- reset  input  1  asynchronous, active-high reset
- tx_data  input  8  byte to transmit
- tx_valid  input  1  tx_data is valid this cycle
- tx_ready  output  1  FIFO can accept a byte (= not full)
- txout  output  1  serial line; idles high
- tx_busy  output  1  high while a frame is on the line (states START/DATA/STOP)
- fifo_count  output  ADDR_W+1  number of bytes queued, excluding the frame in flight

Behaviour:
- Reset (async, immediate):
  - txout=1, tx_busy=0, tx_ready=1, fifo_count=0.
  - FIFO pointers cleared; tick counter=0; FSM=IDLE.
  - Reset mid-frame aborts the frame; the line returns high at once, and the queued bytes are discarded.
- Tick generator:
  - Free-running counter 0..2*(CLK_DIV+1)-1, starting after reset.
  - `tick` is a 1-cycle internal pulse in the cycle the counter is at its max; the counter wraps to 0 on the next edge.
  - First tick falls 54 cycles after reset deassertion (default).
- FIFO:
  - Push when tx_valid && tx_ready: write to the wr pointer, wr pointer +1 (wraps mod depth).
  - tx_ready = (fifo_count != 2**ADDR_W). If tx_valid is high while full, the byte is ignored and there is no overflow.
  - Pop occurs only at frame start (see FSM).
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap with no gap; FIFO ordering is strictly first-in first-out.
- FSM states: IDLE, START, DATA, STOP. The bit-tick counter counts 0..15 and the bit index counts 0..7.
  - IDLE: txout=1. On a clk edge where tick=1 and fifo_count!=0: pop the head into the shift register, go to START, txout=0, bit-tick counter=0.
  - START: after 16 ticks, go to DATA with bit index 0; txout=shift[0].
  - DATA: every 16 ticks, shift right and bit index +1; txout = next LSB. After the 16th tick of bit 7, go to STOP with txout=1.
  - STOP: after 16 ticks, the frame ends.
    - If fifo_count!=0 at that edge: pop and enter START directly (txout=0 at the same edge). Back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- Frame timing:
  - Every frame starts on a tick edge. Each bit lasts exactly 16 ticks = 32*(CLK_DIV+1) clk cycles.
  - One frame = 10 bit times = 8640 cycles (default).
  - Latency from accepting a byte into an empty idle block: 1 to 2*(CLK_DIV+1) cycles, i.e. wait for the next tick.
- tx_busy is high from the start-bit edge until the edge at the end of the last stop bit where the FSM enters IDLE.
- A push during a frame never disturbs the frame in flight.

Test Plan:
- Single byte: reset, push 8'h39 → txout sequence 0,1,0,0,1,1,1,0,0,1. Each level holds 864 cycles (±0), then txout stays 1 and tx_busy=0.
- Back-to-back: push 8'h55, 8'hA3 on consecutive cycles → two frames with no idle between them.
  - Frame 1 data bits 1,0,1,0,1,0,1,0; frame 2 data bits 1,1,0,0,0,1,0,1.
  - Total busy time 17280 cycles.
- Full FIFO: while frame 1 is in flight, push until tx_ready=0 → fifo_count=4. A 6th push with tx_valid held is not accepted. All 5 accepted bytes emerge in order.
- Reset mid-frame: assert reset during data bit 3 → txout=1 within the same cycle and fifo_count=0. After release with no push, the line stays high.
- Simultaneous push/pop: with fifo_count=2, push on the exact cycle of a frame-start pop → fifo_count stays 2 and the byte order is preserved.
- Loopback: connect txout to the UART receiver rxin and send 8'h00, 8'hFF, 8'h39 → the receiver reports the identical bytes.
